// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg
//   Shared types and defaults for the command-driven counter controller.
//   - cmd_op_e     : command opcodes carried on the command port
//   - ctrl_state_e : controller FSM states
//   - WIDTH_DEFAULT: default width of the count value and period register
// ---------------------------------------------------------------------------
package counter_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_START = 2'd1,
    OP_PAUSE = 2'd2,
    OP_STOP  = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/counter_ctrl_if.sv
// ---------------------------------------------------------------------------
// counter_ctrl_if
//   Valid/ready command port between a CSR front end and counter_ctrl.
//   Signals:
//     cmd_valid : command present (sender holds it until accepted)
//     cmd_ready : controller can accept a command this cycle
//     cmd_op    : opcode (LOAD/START/PAUSE/STOP)
//     cmd_data  : period value for LOAD, ignored otherwise
//   Modports:
//     master : command sender (front end)
//     slave  : command receiver (counter_ctrl)
// ---------------------------------------------------------------------------
interface counter_ctrl_if
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );

endinterface

// File: rtl/counter_ctrl_tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//   Prescaler for the counter: while run is high it counts 0..PRESCALE-1 and
//   asserts tick (combinationally) on the cycle it sits at PRESCALE-1, then
//   wraps to 0. It holds its count while run is low; clear forces it to 0.
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous active-high reset
//     run   : advance the prescaler this cycle
//     clear : return the prescaler to 0 on the next edge
//     tick  : count-tick strobe
//   Parameters:
//     PRESCALE : clock cycles per tick, 1..256 (1 = tick every run cycle)
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  // At least one bit so PRESCALE=1 still elaborates; the count then stays 0.
  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_reg;

  assign tick = run && (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (run) begin
      count_reg <= tick ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// ---------------------------------------------------------------------------
// counter_ctrl
//   Command-driven controller around an up-counter with prescaler and
//   terminal-count compare. Commands LOAD/START/PAUSE/STOP arrive on a
//   valid/ready port; a one-cycle done pulse marks the terminal count.
//   Ports:
//     clk     : clock, rising edge
//     reset   : synchronous active-high reset
//     cmd     : command port (counter_ctrl_if.slave)
//     value   : current count
//     busy    : registered, high in RUN or PAUSE
//     done    : registered one-cycle pulse after the terminal tick
//     cmd_err : registered one-cycle pulse after an illegal accepted command
//   Parameters:
//     WIDTH    : width of count value and period register
//     PRESCALE : clock cycles per count tick (1..256)
//   Build option:
//     COUNTER_CTRL_AUTO_RELOAD_EN : when defined, the terminal tick reloads
//     value to 0 and keeps running; otherwise it returns to IDLE with value
//     holding the period.
// ---------------------------------------------------------------------------
module counter_ctrl
  import counter_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEFAULT,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  counter_ctrl_if.slave    cmd,
  output logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             cmd_err
);

  ctrl_state_e      state_reg,  state_next;
  logic [WIDTH-1:0] value_reg,  value_next;
  logic [WIDTH-1:0] period_reg, period_next;
  logic             done_reg,   done_next;
  logic             err_reg,    err_next;

  logic accept;
  logic run;
  logic clear;
  logic tick;
  logic terminal;

  // Commands are refused only while done is being presented.
  assign cmd.cmd_ready = !done_reg;
  assign accept        = cmd.cmd_valid && !done_reg;

  // An accepted command owns the cycle: the prescaler stalls and any tick
  // that would have fired is discarded, so command and tick never collide.
  assign run      = (state_reg == ST_RUN) && !accept;
  assign terminal = tick && (value_reg == period_reg);

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clear (clear),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      value_reg  <= '0;
      period_reg <= '1;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      value_reg  <= value_next;
      period_reg <= period_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    value_next  = value_reg;
    period_next = period_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    clear       = 1'b0;

    if (accept) begin
      case (cmd.cmd_op)
        OP_LOAD: begin
          if (state_reg == ST_RUN) begin
            err_next = 1'b1;
          end else begin
            period_next = cmd.cmd_data;
          end
        end
        OP_START: begin
          state_next = ST_RUN;
          // Resuming from PAUSE keeps value and prescaler phase.
          if (state_reg != ST_PAUSE) begin
            value_next = '0;
            clear      = 1'b1;
          end
        end
        OP_PAUSE: begin
          if (state_reg == ST_RUN) begin
            state_next = ST_PAUSE;
          end else begin
            err_next = 1'b1;
          end
        end
        OP_STOP: begin
          state_next = ST_IDLE;
          value_next = '0;
          clear      = 1'b1;
        end
        default: ;
      endcase
    end else if (tick) begin
      if (terminal) begin
        done_next = 1'b1;
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
        value_next = '0;
`else
        state_next = ST_IDLE;
`endif
      end else begin
        value_next = value_reg + 1'b1;
      end
    end
  end

  assign value   = value_reg;
  assign busy    = (state_reg != ST_IDLE);
  assign done    = done_reg;
  assign cmd_err = err_reg;

endmodule

// File: tb/tb_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_ctrl
//   Directed self-checking bench for counter_ctrl. Two instances share one
//   clock and reset: dut1 with PRESCALE=1 and dut4 with PRESCALE=4.
//   Inputs change and outputs are sampled on the falling edge.
//   Build option: COUNTER_CTRL_AUTO_RELOAD_EN selects auto-reload
//   expectations and the auto-reload-only steps.
// ---------------------------------------------------------------------------
module tb_counter_ctrl;
  import counter_pkg::*;

`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  counter_ctrl_if #(.WIDTH(8)) bus1 ();
  counter_ctrl_if #(.WIDTH(8)) bus4 ();

  logic [7:0] value1, value4;
  logic       busy1, busy4, done1, done4, err1, err4;

  counter_ctrl #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clk     (clk),
    .reset   (reset),
    .cmd     (bus1),
    .value   (value1),
    .busy    (busy1),
    .done    (done1),
    .cmd_err (err1)
  );

  counter_ctrl #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clk     (clk),
    .reset   (reset),
    .cmd     (bus4),
    .value   (value4),
    .busy    (busy4),
    .done    (done4),
    .cmd_err (err4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Present a command at a falling edge and hold it until accepted; returns
  // on the falling edge right after the accepting rising edge.
  task automatic send(input bit sel4, input cmd_op_e op, input logic [7:0] data);
    int   n;
    logic acc;
    n = 0;
    if (sel4) begin
      bus4.cmd_valid = 1'b1; bus4.cmd_op = op; bus4.cmd_data = data;
    end else begin
      bus1.cmd_valid = 1'b1; bus1.cmd_op = op; bus1.cmd_data = data;
    end
    do begin
      acc = sel4 ? bus4.cmd_ready : bus1.cmd_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 50);
    check("cmd_accepted", {31'd0, acc}, 32'd1);
    bus1.cmd_valid = 1'b0;
    bus4.cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    bus1.cmd_valid = 1'b0; bus1.cmd_op = OP_LOAD; bus1.cmd_data = '0;
    bus4.cmd_valid = 1'b0; bus4.cmd_op = OP_LOAD; bus4.cmd_data = '0;
    step(2);

    // Reset state
    check("rst_value", value1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_err", err1, 0);
    check("rst_ready", bus1.cmd_ready, 1);
    check("rst_value4", value4, 0);
    check("rst_ready4", bus4.cmd_ready, 1);
    reset = 1'b0;

    // LOAD 5, START, PRESCALE=1: 0..5 then done
    send(0, OP_LOAD, 8'd5);
    check("t1_load_busy", busy1, 0);
    send(0, OP_START, 8'd0);
    for (int k = 0; k <= 5; k++) begin
      check("t1_value", value1, k);
      check("t1_busy", busy1, 1);
      check("t1_done_low", done1, 0);
      step(1);
    end
    check("t1_done", done1, 1);
    check("t1_ready_low", bus1.cmd_ready, 0);
    check("t1_value_at_done", value1, AUTO ? 0 : 5);
    check("t1_busy_at_done", busy1, AUTO ? 1 : 0);
    step(1);
    check("t1_done_end", done1, 0);
    check("t1_ready_back", bus1.cmd_ready, 1);
    check("t1_value_after", value1, AUTO ? 1 : 5);
    check("t1_busy_after", busy1, AUTO ? 1 : 0);
    send(0, OP_STOP, 8'd0);
    check("t1_stop_value", value1, 0);
    check("t1_stop_busy", busy1, 0);

    // PRESCALE=4, LOAD 2, START: tick every 4 cycles, done after 12
    send(1, OP_LOAD, 8'd2);
    send(1, OP_START, 8'd0);
    for (int k = 0; k <= 13; k++) begin
      int ev;
      ev = (k < 4) ? 0 : (k < 8) ? 1 : (k < 12) ? 2 : (AUTO ? 0 : 2);
      check("t2_value", value4, ev);
      check("t2_done", done4, (k == 12) ? 1 : 0);
      check("t2_ready", bus4.cmd_ready, (k == 12) ? 0 : 1);
      check("t2_busy", busy4, (AUTO || k < 12) ? 1 : 0);
      step(1);
    end
    send(1, OP_STOP, 8'd0);
    check("t2_stop_value", value4, 0);

    // Run to 3, PAUSE, hold, LOAD 7 while paused, resume 4..7
    send(0, OP_START, 8'd0);
    check("t3_start_value", value1, 0);
    step(3);
    check("t3_value3", value1, 3);
    send(0, OP_PAUSE, 8'd0);
    check("t3_pause_value", value1, 3);
    check("t3_pause_busy", busy1, 1);
    check("t3_pause_err", err1, 0);
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("t3_frozen", value1, 3);
    end
    send(0, OP_LOAD, 8'd7);
    check("t3_load_err", err1, 0);
    check("t3_load_value", value1, 3);
    send(0, OP_START, 8'd0);
    check("t3_resume_value", value1, 3);
    check("t3_resume_busy", busy1, 1);
    for (int k = 4; k <= 7; k++) begin
      step(1);
      check("t3_value", value1, k);
      check("t3_done_low", done1, 0);
    end
    step(1);
    check("t3_done", done1, 1);
    check("t3_value_at_done", value1, AUTO ? 0 : 7);
    send(0, OP_STOP, 8'd0);

    // LOAD in RUN: cmd_err, period stays 7
    send(0, OP_START, 8'd0);
    send(0, OP_LOAD, 8'd9);
    check("t4_err", err1, 1);
    check("t4_err_value", value1, 0);
    step(1);
    check("t4_err_end", err1, 0);
    check("t4_value1", value1, 1);
    for (int k = 2; k <= 7; k++) begin
      step(1);
      check("t4_value", value1, k);
    end
    step(1);
    check("t4_done_at_7", done1, 1);
    check("t4_value_at_done", value1, AUTO ? 0 : 7);
    send(0, OP_STOP, 8'd0);
    // PAUSE in IDLE
    send(0, OP_PAUSE, 8'd0);
    check("t4_pause_idle_err", err1, 1);
    check("t4_pause_idle_busy", busy1, 0);
    step(1);
    check("t4_pause_idle_err_end", err1, 0);
    check("t4_pause_idle_busy2", busy1, 0);

    // STOP on the terminal tick (period 3)
    send(0, OP_LOAD, 8'd3);
    send(0, OP_START, 8'd0);
    step(3);
    check("t5_value3", value1, 3);
    send(0, OP_STOP, 8'd0);
    check("t5_stop_done", done1, 0);
    check("t5_stop_value", value1, 0);
    check("t5_stop_busy", busy1, 0);
    step(1);
    check("t5_stop_done2", done1, 0);
    // PAUSE on the terminal tick freezes at period
    send(0, OP_START, 8'd0);
    step(3);
    send(0, OP_PAUSE, 8'd0);
    check("t5_pause_done", done1, 0);
    check("t5_pause_value", value1, 3);
    check("t5_pause_busy", busy1, 1);
    step(1);
    check("t5_pause_done2", done1, 0);
    check("t5_pause_value2", value1, 3);
    send(0, OP_STOP, 8'd0);

    // Reset mid-RUN at value 4
    send(0, OP_LOAD, 8'd10);
    send(0, OP_START, 8'd0);
    step(4);
    check("t5_value4", value1, 4);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t5_rst_value", value1, 0);
    check("t5_rst_busy", busy1, 0);
    check("t5_rst_done", done1, 0);
    check("t5_rst_ready", bus1.cmd_ready, 1);
    // Period back to 255: counting passes 10
    send(0, OP_START, 8'd0);
    step(20);
    check("t5_period_reset", value1, 20);
    check("t5_period_busy", busy1, 1);
    send(0, OP_STOP, 8'd0);

    // Period 0: terminal on first tick, value stays 0
    send(0, OP_LOAD, 8'd0);
    send(0, OP_START, 8'd0);
    check("t6_p0_value", value1, 0);
    step(1);
    check("t6_p0_done", done1, 1);
    check("t6_p0_value_done", value1, 0);
    check("t6_p0_busy", busy1, AUTO ? 1 : 0);
`ifdef COUNTER_CTRL_AUTO_RELOAD_EN
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("t6_ar_p0_done", done1, 1);
      check("t6_ar_p0_value", value1, 0);
      check("t6_ar_p0_busy", busy1, 1);
    end
    // Done every cycle keeps the port closed; reset to regain control
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t6_ar_rst_done", done1, 0);
    send(0, OP_LOAD, 8'd255);
    send(0, OP_START, 8'd0);
    for (int k = 1; k <= 520; k++) begin
      step(1);
      check("t6_ar_full_done", done1, (k % 256 == 0) ? 1 : 0);
      check("t6_ar_full_value", value1, k % 256);
    end
    send(0, OP_STOP, 8'd0);
`else
    step(1);
    check("t6_p0_done_end", done1, 0);
    check("t6_p0_value_end", value1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
